// File: rtl/rf_pkg.sv
// Shared types and constants for the banked register file.
package rf_pkg;

    localparam int unsigned BYTE = 8;

    typedef enum logic [1:0] {
        RF_IDLE,
        RF_COPY,
        RF_SWITCH
    } rf_state_t;

endpackage

// File: rtl/banked_register_file_if.sv
// Datapath / interrupt-controller side of the banked register file.
interface banked_register_file_if
    import rf_pkg::*;
#(
    parameter int unsigned WORD        = 16,
    parameter int unsigned REGISTERS   = 8,
    parameter int unsigned READ_PORTS  = 2,
    parameter int unsigned WRITE_PORTS = 2,
    parameter int unsigned BANKS       = 4
);

    logic [WRITE_PORTS-1:0][WORD/BYTE-1:0]         Reg_wr;
    logic [WRITE_PORTS-1:0][$clog2(REGISTERS)-1:0] wr_addr;
    logic [WRITE_PORTS-1:0][WORD-1:0]              wr_data;
    logic [READ_PORTS-1:0][$clog2(REGISTERS)-1:0]  rd_addr;
    logic [READ_PORTS-1:0][WORD-1:0]               rd_data;
    logic                                          switch_req;
    logic [$clog2(BANKS)-1:0]                      bank_sel;
    logic                                          copy_en;
    logic                                          switch_ack;
    logic                                          busy;
    logic [$clog2(BANKS)-1:0]                      active_bank;

    modport master (
        output Reg_wr, wr_addr, wr_data, rd_addr, switch_req, bank_sel, copy_en,
        input  rd_data, switch_ack, busy, active_bank
    );

    modport slave (
        input  Reg_wr, wr_addr, wr_data, rd_addr, switch_req, bank_sel, copy_en,
        output rd_data, switch_ack, busy, active_bank
    );

endinterface

// File: rtl/rf_bank_seq.sv
// Bank-switch sequencer: IDLE/COPY/SWITCH FSM, copy index, target latch, active bank.
module rf_bank_seq
    import rf_pkg::*;
#(
    parameter int unsigned REGISTERS = 8,
    parameter int unsigned BANKS     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         switch_req_i,
    input  logic [$clog2(BANKS)-1:0]     bank_sel_i,
    input  logic                         copy_en_i,
    output logic                         busy_o,
    output logic                         switch_ack_o,
    output logic [$clog2(BANKS)-1:0]     active_bank_o,
    output logic [$clog2(BANKS)-1:0]     target_bank_o,
    output logic                         copy_valid_o,
    output logic [$clog2(REGISTERS)-1:0] copy_idx_o,
    output logic                         mirror_en_o
);

    localparam int unsigned AW = $clog2(REGISTERS);
    localparam int unsigned BW = $clog2(BANKS);

    rf_state_t       state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [BW-1:0]   target_q, target_d;
    logic [BW-1:0]   active_q, active_d;
    logic            copied_q, copied_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RF_IDLE;
            idx_q    <= '0;
            target_q <= '0;
            active_q <= '0;
            copied_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            target_q <= target_d;
            active_q <= active_d;
            copied_q <= copied_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        target_d = target_q;
        active_d = active_q;
        copied_d = copied_q;
        case (state_q)
            RF_IDLE: begin
                if (switch_req_i) begin
                    target_d = bank_sel_i;
                    idx_d    = '0;
                    // Copying a bank onto itself is pointless; go straight to the switch.
                    if (copy_en_i && (bank_sel_i != active_q)) begin
                        state_d  = RF_COPY;
                        copied_d = 1'b1;
                    end else begin
                        state_d  = RF_SWITCH;
                        copied_d = 1'b0;
                    end
                end
            end
            RF_COPY: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == AW'(REGISTERS - 1)) begin
                    state_d = RF_SWITCH;
                end
            end
            RF_SWITCH: begin
                active_d = target_q;
                copied_d = 1'b0;
                state_d  = RF_IDLE;
            end
            default: state_d = RF_IDLE;
        endcase
    end

    assign busy_o        = (state_q != RF_IDLE);
    assign switch_ack_o  = (state_q == RF_SWITCH);
    assign active_bank_o = active_q;
    assign target_bank_o = target_q;
    assign copy_valid_o  = (state_q == RF_COPY);
    assign copy_idx_o    = idx_q;
    // The SWITCH cycle still mirrors writes when a copy preceded it.
    assign mirror_en_o   = (state_q == RF_COPY) || ((state_q == RF_SWITCH) && copied_q);

endmodule

// File: rtl/banked_register_file.sv
// Multi-bank, multi-port, byte-writable register file with copy-on-switch sequencer.
// Optional macro RF_BYPASS_EN forwards same-cycle write data to the read ports.
module banked_register_file
    import rf_pkg::*;
#(
    parameter int unsigned WORD        = 16,
    parameter int unsigned REGISTERS   = 8,
    parameter int unsigned READ_PORTS  = 2,
    parameter int unsigned WRITE_PORTS = 2,
    parameter int unsigned BANKS       = 4
) (
    input logic                   clk,
    input logic                   reset,
    banked_register_file_if.slave bus
);

    localparam int unsigned NB = WORD / BYTE;
    localparam int unsigned AW = $clog2(REGISTERS);
    localparam int unsigned BW = $clog2(BANKS);

    logic [WORD-1:0] mem_q [BANKS][REGISTERS];
    logic [WORD-1:0] mem_d [BANKS][REGISTERS];

    logic [BW-1:0]                   active_bank;
    logic [BW-1:0]                   target_bank;
    logic                            copy_valid;
    logic [AW-1:0]                   copy_idx;
    logic                            mirror_en;
    logic [READ_PORTS-1:0][WORD-1:0] rd_data;

    rf_bank_seq #(
        .REGISTERS (REGISTERS),
        .BANKS     (BANKS)
    ) u_seq (
        .clk           (clk),
        .reset         (reset),
        .switch_req_i  (bus.switch_req),
        .bank_sel_i    (bus.bank_sel),
        .copy_en_i     (bus.copy_en),
        .busy_o        (bus.busy),
        .switch_ack_o  (bus.switch_ack),
        .active_bank_o (active_bank),
        .target_bank_o (target_bank),
        .copy_valid_o  (copy_valid),
        .copy_idx_o    (copy_idx),
        .mirror_en_o   (mirror_en)
    );

    // Copy first, then writes in ascending port order: written bytes and higher ports win.
    always_comb begin
        mem_d = mem_q;
        if (copy_valid) begin
            mem_d[target_bank][copy_idx] = mem_q[active_bank][copy_idx];
        end
        for (int p = 0; p < WRITE_PORTS; p++) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.Reg_wr[p][b]) begin
                    mem_d[active_bank][bus.wr_addr[p]][b*BYTE +: BYTE] =
                        bus.wr_data[p][b*BYTE +: BYTE];
                    if (mirror_en) begin
                        mem_d[target_bank][bus.wr_addr[p]][b*BYTE +: BYTE] =
                            bus.wr_data[p][b*BYTE +: BYTE];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < BANKS; k++) begin
                for (int r = 0; r < REGISTERS; r++) begin
                    mem_q[k][r] <= '0;
                end
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        for (int q = 0; q < READ_PORTS; q++) begin
            rd_data[q] = mem_q[active_bank][bus.rd_addr[q]];
`ifdef RF_BYPASS_EN
            for (int p = 0; p < WRITE_PORTS; p++) begin
                for (int b = 0; b < NB; b++) begin
                    if (bus.Reg_wr[p][b] && (bus.wr_addr[p] == bus.rd_addr[q])) begin
                        rd_data[q][b*BYTE +: BYTE] = bus.wr_data[p][b*BYTE +: BYTE];
                    end
                end
            end
`endif
        end
    end

    assign bus.rd_data     = rd_data;
    assign bus.active_bank = active_bank;

endmodule

// File: tb/tb_banked_register_file.sv
// Directed, table-driven bench for banked_register_file (4 banks x 8 x 16 bit, 2R/2W).
module tb_banked_register_file;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    banked_register_file_if #(
        .WORD(16), .REGISTERS(8), .READ_PORTS(2), .WRITE_PORTS(2), .BANKS(4)
    ) bus ();

    banked_register_file #(
        .WORD(16), .REGISTERS(8), .READ_PORTS(2), .WRITE_PORTS(2), .BANKS(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  be0;
        logic [2:0]  a0;
        logic [15:0] d0;
        logic [1:0]  be1;
        logic [2:0]  a1;
        logic [15:0] d1;
        logic [2:0]  ra;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.Reg_wr     = '0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.switch_req = 1'b0;
        bus.bank_sel   = '0;
        bus.copy_en    = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input int a, input logic [15:0] exp);
        bus.rd_addr[0] = 3'(a);
        bus.rd_addr[1] = 3'(a);
        #1;
        check(nm, {16'h0, bus.rd_data[0]}, {16'h0, exp});
        check({nm, "_p1"}, {16'h0, bus.rd_data[1]}, {16'h0, exp});
    endtask

    task automatic wr1(input int a, input logic [15:0] d);
        bus.Reg_wr[0]  = 2'b11;
        bus.wr_addr[0] = 3'(a);
        bus.wr_data[0] = d;
        @(posedge clk); #1;
        bus.Reg_wr = '0;
    endtask

    // Issue a request, then count busy cycles with a bound and note where ack appeared.
    task automatic do_switch(input logic [1:0] b, input logic c, input int exp_busy);
        int n      = 0;
        int ack_at = -1;
        bus.switch_req = 1'b1;
        bus.bank_sel   = b;
        bus.copy_en    = c;
        @(posedge clk); #1;
        bus.switch_req = 1'b0;
        bus.copy_en    = 1'b0;
        while (bus.busy && n < 20) begin
            if (bus.switch_ack) ack_at = n;
            n++;
            @(posedge clk); #1;
        end
        check("switch_busy_cycles", n, exp_busy);
        check("switch_ack_pos", ack_at, exp_busy - 1);
        check("switch_active", {30'h0, bus.active_bank}, {30'h0, b});
    endtask

    initial begin
        int n;
        int ack_at;

        vecs[0] = '{2'b11, 3'd3, 16'h1234, 2'b10, 3'd3, 16'hAB00, 3'd3, 16'hAB34};
        vecs[1] = '{2'b11, 3'd1, 16'h5555, 2'b00, 3'd0, 16'hFFFF, 3'd1, 16'h5555};
        vecs[2] = '{2'b01, 3'd1, 16'h77AA, 2'b00, 3'd1, 16'h0000, 3'd1, 16'h55AA};
        vecs[3] = '{2'b11, 3'd2, 16'h1111, 2'b11, 3'd2, 16'h2222, 3'd2, 16'h2222};
        vecs[4] = '{2'b10, 3'd4, 16'hCD00, 2'b01, 3'd4, 16'h00EF, 3'd4, 16'hCDEF};
        vecs[5] = '{2'b11, 3'd5, 16'h0F0F, 2'b11, 3'd6, 16'hF0F0, 3'd5, 16'h0F0F};
        vecs[6] = '{2'b00, 3'd0, 16'h0000, 2'b00, 3'd0, 16'h0000, 3'd6, 16'hF0F0};
        vecs[7] = '{2'b00, 3'd3, 16'hFFFF, 2'b00, 3'd3, 16'hFFFF, 3'd3, 16'hAB34};

        idle_inputs();
        bus.rd_addr = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state and every register of every bank reads zero.
        check("rst_active", {30'h0, bus.active_bank}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_ack", {31'h0, bus.switch_ack}, 32'h0);
        for (int r = 0; r < 8; r++) rd_chk("rst_b0", r, 16'h0);
        for (int b = 1; b < 4; b++) begin
            do_switch(2'(b), 1'b0, 1);
            for (int r = 0; r < 8; r++) rd_chk("rst_bank", r, 16'h0);
        end
        do_switch(2'd0, 1'b0, 1);

        // Byte-wise multi-port writes in bank 0.
        foreach (vecs[i]) begin
            bus.Reg_wr[0]  = vecs[i].be0;
            bus.wr_addr[0] = vecs[i].a0;
            bus.wr_data[0] = vecs[i].d0;
            bus.Reg_wr[1]  = vecs[i].be1;
            bus.wr_addr[1] = vecs[i].a1;
            bus.wr_data[1] = vecs[i].d1;
            @(posedge clk); #1;
            bus.Reg_wr = '0;
            rd_chk($sformatf("vec%0d", i), vecs[i].ra, vecs[i].exp);
        end

        // Copy to bank 2 with a mirrored write to R0 and a byte write colliding with the copy.
        for (int r = 0; r < 8; r++) wr1(r, 16'h1000 + 16'(r));
        bus.switch_req = 1'b1;
        bus.bank_sel   = 2'd2;
        bus.copy_en    = 1'b1;
        @(posedge clk); #1;
        bus.switch_req = 1'b0;
        bus.copy_en    = 1'b0;
        n      = 0;
        ack_at = -1;
        while (bus.busy && n < 20) begin
            if (bus.switch_ack) ack_at = n;
            bus.Reg_wr = '0;
            if (n == 2) begin
                bus.Reg_wr[0]  = 2'b11;
                bus.wr_addr[0] = 3'd0;
                bus.wr_data[0] = 16'hBEEF;
            end
            if (n == 3) begin
                bus.Reg_wr[1]  = 2'b01;
                bus.wr_addr[1] = 3'd3;
                bus.wr_data[1] = 16'h77CC;
            end
            n++;
            @(posedge clk); #1;
        end
        bus.Reg_wr = '0;
        check("copy_busy_cycles", n, 9);
        check("copy_ack_pos", ack_at, 8);
        check("copy_active", {30'h0, bus.active_bank}, 32'd2);
        rd_chk("copy_b2_r0", 0, 16'hBEEF);
        rd_chk("copy_b2_r3", 3, 16'h10CC);
        for (int r = 1; r < 8; r++) begin
            if (r != 3) rd_chk("copy_b2", r, 16'h1000 + 16'(r));
        end
        do_switch(2'd0, 1'b0, 1);
        rd_chk("copy_b0_r0", 0, 16'hBEEF);
        rd_chk("copy_b0_r3", 3, 16'h10CC);
        do_switch(2'd0, 1'b1, 1);

        // Switch without copy; a request during SWITCH is dropped.
        bus.switch_req = 1'b1;
        bus.bank_sel   = 2'd1;
        @(posedge clk); #1;
        bus.bank_sel = 2'd3;
        bus.copy_en  = 1'b1;
        check("sw_busy", {31'h0, bus.busy}, 32'h1);
        check("sw_ack", {31'h0, bus.switch_ack}, 32'h1);
        check("sw_active_old", {30'h0, bus.active_bank}, 32'd0);
        @(posedge clk); #1;
        bus.switch_req = 1'b0;
        bus.copy_en    = 1'b0;
        check("sw_active_new", {30'h0, bus.active_bank}, 32'd1);
        check("sw_ack_gone", {31'h0, bus.switch_ack}, 32'h0);
        @(posedge clk); #1;
        check("ignored_busy", {31'h0, bus.busy}, 32'h0);
        check("ignored_active", {30'h0, bus.active_bank}, 32'd1);
        rd_chk("b1_r0", 0, 16'h0);
        do_switch(2'd0, 1'b0, 1);

        // Reset while the copy index is 4.
        bus.switch_req = 1'b1;
        bus.bank_sel   = 2'd3;
        bus.copy_en    = 1'b1;
        @(posedge clk); #1;
        bus.switch_req = 1'b0;
        bus.copy_en    = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midcopy_busy", {31'h0, bus.busy}, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_active", {30'h0, bus.active_bank}, 32'd0);
        check("midrst_busy", {31'h0, bus.busy}, 32'h0);
        for (int r = 0; r < 8; r++) rd_chk("midrst_b0", r, 16'h0);
        do_switch(2'd3, 1'b0, 1);
        for (int r = 0; r < 8; r++) rd_chk("midrst_b3", r, 16'h0);

        // Read during write.
        bus.Reg_wr[0]  = 2'b11;
        bus.wr_addr[0] = 3'd5;
        bus.wr_data[0] = 16'h5A5A;
`ifdef RF_BYPASS_EN
        rd_chk("bypass_same", 5, 16'h5A5A);
`else
        rd_chk("nobypass_same", 5, 16'h0000);
`endif
        @(posedge clk); #1;
        bus.Reg_wr = '0;
        rd_chk("rdw_next", 5, 16'h5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
